// File: rtl/outing_pkg.sv
// Shared types and helpers for the outing scheduler.
package outing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATHER   = 2'd1,
        OUTING   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Width that holds the largest counter load plus one.
    function automatic int cnt_width(input int g, input int o, input int c);
        int m;
        m = g;
        if (o > m) m = o;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant of the first requester after the pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [N-1:0]  w_hi;
    logic          w_found;

    // Requests strictly above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            w_hi[i] = req[i] && (i > int'(r_ptr));
        end
    end

    always_comb begin
        gnt     = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_hi[i]) begin
                gnt[i]  = 1'b1;
                w_idx   = PW'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                gnt[i]  = 1'b1;
                w_idx   = PW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PW'(N - 1);
        end else if (advance && |req) begin
            r_ptr <= w_idx;
        end
    end

endmodule

// File: rtl/outing_scheduler.sv
// Outing controller: gathers a two-group quorum, grants one member per group,
// times the outing and enforces a cooldown before the next one.
//
// state    | meaning
// IDLE     | waiting for a member of each group to request
// GATHER   | quorum must persist while counter runs down
// OUTING   | grants frozen, going_out high until timeout or a grantee drops
// COOLDOWN | requests ignored until counter expires
module outing_scheduler
    import outing_pkg::*;
#(
    parameter int N_HIKE     = 2,
    parameter int N_BALL     = 2,
    parameter int GATHER_CYC = 4,
    parameter int OUT_CYC    = 8,
    parameter int COOL_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_HIKE-1:0] hike_req,
    input  logic [N_BALL-1:0] ball_req,
    output logic [N_HIKE-1:0] hike_gnt,
    output logic [N_BALL-1:0] ball_gnt,
    output logic              going_out,
    output logic              busy
);

    localparam int CW = cnt_width(GATHER_CYC, OUT_CYC, COOL_CYC);
    localparam logic [CW-1:0] GATHER_LD = CW'(GATHER_CYC - 1);
    localparam logic [CW-1:0] OUT_LD    = CW'(OUT_CYC - 1);
    localparam logic [CW-1:0] COOL_LD   = CW'(COOL_CYC - 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [N_HIKE-1:0] r_hike_gnt;
    logic [N_BALL-1:0] r_ball_gnt;
    logic              r_going_out;
    logic              r_busy;

    logic              w_quorum;
    logic              w_advance;
    logic              w_early_end;
    logic [N_HIKE-1:0] w_hike_arb;
    logic [N_BALL-1:0] w_ball_arb;

    assign w_quorum    = (|hike_req) & (|ball_req);
    assign w_advance   = (r_state == GATHER) && w_quorum && (r_cnt == '0);
    assign w_early_end = !(|(hike_req & r_hike_gnt)) || !(|(ball_req & r_ball_gnt));

    rr_arbiter #(.N(N_HIKE)) u_hike_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (hike_req),
        .advance (w_advance),
        .gnt     (w_hike_arb)
    );

    rr_arbiter #(.N(N_BALL)) u_ball_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (ball_req),
        .advance (w_advance),
        .gnt     (w_ball_arb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hike_gnt  <= '0;
            r_ball_gnt  <= '0;
            r_going_out <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_quorum) begin
                        r_state <= GATHER;
                        r_cnt   <= GATHER_LD;
                        r_busy  <= 1'b1;
                    end
                end
                GATHER: begin
                    if (!w_quorum) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state     <= OUTING;
                        r_cnt       <= OUT_LD;
                        r_hike_gnt  <= w_hike_arb;
                        r_ball_gnt  <= w_ball_arb;
                        r_going_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                OUTING: begin
                    if (w_early_end || r_cnt == '0) begin
                        r_state     <= COOLDOWN;
                        r_cnt       <= COOL_LD;
                        r_hike_gnt  <= '0;
                        r_ball_gnt  <= '0;
                        r_going_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_hike_gnt  <= '0;
                    r_ball_gnt  <= '0;
                    r_going_out <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign hike_gnt  = r_hike_gnt;
    assign ball_gnt  = r_ball_gnt;
    assign going_out = r_going_out;
    assign busy      = r_busy;

endmodule
